// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-drain UART transmitter.
package uart_pkg;

  // Transmit FSM states; PARITY is only visited when even parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Level driven on the line between frames and during the stop bit.
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per bit time, truncating integer division.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last count.
// Held at zero while clear is high so every frame starts on a fresh bit time.
module baud_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic bitDone
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  // Free-running modulo counter, wrapping on the last cycle of each bit.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bitDone = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Self-draining UART transmitter for a show-ahead FIFO read port.
// Pops one word whenever the FIFO is non-empty and en is high, then sends it
// as start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Build option: define FIFO_UART_TX_PARITY_EN for 8E1 frames (default 8N1).
//
// FIFO handshake: read is a registered one-cycle pop strobe, raised only from
// IDLE and only after empty was sampled low; the head word is captured on the
// same edge that raises read, so later changes on dataIn/empty are ignored.
// tx is registered from the current state and so trails the state by a cycle:
// the start bit appears on the cycle after the pop cycle.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DATA_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              en,
  input  logic              empty,
  input  logic [DATA_W-1:0] dataIn,
  output logic              read,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        sentCount,
  output tx_state_t         dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              bit_done;
  logic              timer_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_bit;
`endif

  // Every non-IDLE state is left exactly on a bit boundary where the timer
  // wraps on its own, so holding it in IDLE restarts it on each state entry.
  assign timer_clear = (state == IDLE);
  assign dbg_state   = state;

  baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (timer_clear),
    .bitDone (bit_done)
  );

  // Frame sequencer with registered pop strobe, line level, busy and counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      read      <= 1'b0;
      busy      <= 1'b0;
      tx        <= UART_IDLE_LEVEL;
      sentCount <= 8'd0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      read <= 1'b0;
      case (state)
        IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (en && !empty) begin
            read    <= 1'b1;
            shreg   <= dataIn;
            bit_idx <= '0;
            busy    <= 1'b1;
            state   <= START;
`ifdef FIFO_UART_TX_PARITY_EN
            par_bit <= ^dataIn;
`endif
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_done) state <= DATA;
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_done) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          tx <= par_bit;
          if (bit_done) state <= STOP;
        end
`endif
        STOP: begin
          tx <= UART_IDLE_LEVEL;
          if (bit_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sentCount <= sentCount + 8'd1;
          end
        end
        default: begin
          tx    <= UART_IDLE_LEVEL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
